// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-shot and auto-reload modes, registered terminal-count pulse.
// Optional sticky underflow flag on port uflow when DOWN_COUNTER_UFLOW_STICKY_EN is defined.
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             reload,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             zero,
    output logic             tc,
    output logic             busy
`ifdef DOWN_COUNTER_UFLOW_STICKY_EN
    ,
    output logic             uflow
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] count, count_next;
    logic [WIDTH-1:0] reload_val, reload_val_next;
    logic             tc_next;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_val <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            reload_val <= reload_val_next;
            tc         <= tc_next;
        end
    end

    // Load wins over counting and over a terminal count landing on the same edge.
    always_comb begin
        state_next      = state;
        count_next      = count;
        reload_val_next = reload_val;
        tc_next         = 1'b0;
        if (load) begin
            count_next      = din;
            reload_val_next = din;
            state_next      = (din != '0) ? RUN : IDLE;
        end else if (state == RUN && en) begin
            if (count > WIDTH'(1)) begin
                count_next = count - WIDTH'(1);
            end else if (count == WIDTH'(1)) begin
                tc_next = 1'b1;
                if (reload && reload_val != '0) begin
                    count_next = reload_val;
                end else begin
                    count_next = '0;
                    state_next = IDLE;
                end
            end else begin
                state_next = IDLE;
            end
        end
    end

`ifdef DOWN_COUNTER_UFLOW_STICKY_EN
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            uflow <= 1'b0;
        end else if (load) begin
            uflow <= 1'b0;
        end else if (tc_next) begin
            uflow <= 1'b1;
        end
    end
`endif

    assign Q    = count;
    assign Qb   = ~count;
    assign zero = (count == '0);
    assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: a spec-level model checked every falling edge,
// plus directed sequences with hand-computed literal expectations.
module tb_down_counter;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             ck = 1'b1;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             reload = 1'b0;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qb;
    logic             zero;
    logic             tc;
    logic             busy;
`ifdef DOWN_COUNTER_UFLOW_STICKY_EN
    logic             uflow;
`endif

    int vectors = 0;
    int miscompares = 0;

    int m_count = 0;
    int m_period = 0;
    bit m_running = 0;
    bit m_tc = 0;
    bit m_uflow = 0;

    down_counter #(.WIDTH(WIDTH)) dut (
        .ck(ck),
        .rst(rst),
        .en(en),
        .load(load),
        .din(din),
        .reload(reload),
        .Q(Q),
        .Qb(Qb),
        .zero(zero),
        .tc(tc),
        .busy(busy)
`ifdef DOWN_COUNTER_UFLOW_STICKY_EN
        ,
        .uflow(uflow)
`endif
    );

    always #5 ck = ~ck;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit l, input int d, input bit e, input bit r);
        load   = l;
        din    = WIDTH'(d);
        en     = e;
        reload = r;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Timer rules: a load restarts a countdown of din, each enabled cycle consumes one
    // unit, and the cycle that consumes the last unit fires tc and either restarts or stops.
    always @(posedge ck or negedge rst) begin
        if (!rst) begin
            m_count = 0; m_period = 0; m_running = 0; m_tc = 0; m_uflow = 0;
        end else if (load) begin
            m_count = int'(din); m_period = int'(din);
            m_running = (din != 0); m_tc = 0; m_uflow = 0;
        end else if (m_running && en) begin
            m_tc = (m_count == 1);
            if (m_count == 1) begin
                m_uflow = 1;
                if (reload && m_period != 0) m_count = m_period;
                else begin m_count = 0; m_running = 0; end
            end else begin
                m_count = m_count - 1;
            end
        end else begin
            m_tc = 0;
        end
    end

    always @(negedge ck) begin
        if (rst) begin
            checkOutput("Q", int'(Q), m_count);
            checkOutput("Qb", int'(Qb), (~m_count) & MASK);
            checkOutput("zero", int'(zero), int'(m_count == 0));
            checkOutput("tc", int'(tc), int'(m_tc));
            checkOutput("busy", int'(busy), int'(m_running));
`ifdef DOWN_COUNTER_UFLOW_STICKY_EN
            checkOutput("uflow", int'(uflow), int'(m_uflow));
`endif
        end
    end

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_Q"}, int'(Q), 0);
        checkOutput({tag, "_Qb"}, int'(Qb), MASK);
        checkOutput({tag, "_zero"}, int'(zero), 1);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_tc"}, int'(tc), 0);
`ifdef DOWN_COUNTER_UFLOW_STICKY_EN
        checkOutput({tag, "_uflow"}, int'(uflow), 0);
`endif
    endtask

    initial begin
        int seq_auto [10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
        int seq_one [5] = '{4, 3, 2, 1, 0};
        int tc_seen;

        #1;
        check_reset_state("reset_initial");
        #1;
        rst = 1'b1;
        tick();

        // Asynchronous clear between edges with a loaded value present.
        applyStimulus(1, 5, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("async_pre_Q", int'(Q), 5);
        checkOutput("async_pre_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1 check_reset_state("async_clear");
        rst = 1'b1;
        tick();

        // One-shot countdown from 5.
        applyStimulus(1, 5, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        checkOutput("oneshot_load_Q", int'(Q), 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("oneshot_seq_Q", int'(Q), seq_one[i]);
            checkOutput("oneshot_seq_tc", int'(tc), (i == 4) ? 1 : 0);
        end
        checkOutput("oneshot_end_busy", int'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("oneshot_hold_Q", int'(Q), 0);
            checkOutput("oneshot_hold_tc", int'(tc), 0);
            checkOutput("oneshot_hold_zero", int'(zero), 1);
        end

        // Auto-reload period 3 for ten edges, then reset in the middle of a period.
        applyStimulus(1, 3, 1, 1);
        tc_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) applyStimulus(0, 0, 1, 1);
            checkOutput("auto_seq_Q", int'(Q), seq_auto[i]);
            if (tc) tc_seen++;
        end
        checkOutput("auto_tc_count", tc_seen, 3);
`ifdef DOWN_COUNTER_UFLOW_STICKY_EN
        checkOutput("auto_uflow_set", int'(uflow), 1);
`endif
        tick();
        checkOutput("midrun_pre_Q", int'(Q), 2);
        #2 rst = 1'b0;
        #1 check_reset_state("midrun_reset");
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        tick();

        // Enable gating holds the count at 2 without a pulse.
        applyStimulus(1, 6, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        repeat (4) tick();
        checkOutput("gate_reach_Q", int'(Q), 2);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("gate_hold_Q", int'(Q), 2);
            checkOutput("gate_hold_tc", int'(tc), 0);
        end
        applyStimulus(0, 0, 1, 0);
        tick();
        checkOutput("gate_resume_Q1", int'(Q), 1);
        tick();
        checkOutput("gate_resume_Q0", int'(Q), 0);
        checkOutput("gate_resume_tc", int'(tc), 1);

        // Load colliding with the terminal-count edge, then a zero load.
        applyStimulus(1, 4, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        repeat (3) tick();
        checkOutput("collide_pre_Q", int'(Q), 1);
        applyStimulus(1, 9, 1, 0);
        tick();
        checkOutput("collide_Q", int'(Q), 9);
        checkOutput("collide_tc", int'(tc), 0);
        checkOutput("collide_busy", int'(busy), 1);
        applyStimulus(1, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        checkOutput("load0_zero", int'(zero), 1);
        checkOutput("load0_busy", int'(busy), 0);
        checkOutput("load0_tc", int'(tc), 0);
        tick();

        // Full-scale load counts down without wrapping.
        applyStimulus(1, 15, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        tick();
        checkOutput("max_load_Q", int'(Q), 14);

        // Period-1 auto-reload pulses every enabled cycle.
        applyStimulus(1, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("period1_Q", int'(Q), 1);
            checkOutput("period1_tc", int'(tc), 1);
        end

        // reload only matters at the Q==1 edge.
        applyStimulus(1, 2, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        tick();
        reload = 1'b1;
        tick();
        checkOutput("late_reload_Q", int'(Q), 2);
        checkOutput("late_reload_busy", int'(busy), 1);
        reload = 1'b0;
        repeat (2) tick();
        checkOutput("late_reload_stop_Q", int'(Q), 0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
